// File: rtl/pixel_mem_arbiter_pkg.sv
// Shared types and display-timing constants for the pixel memory arbiter.
package pxl_arb_pkg;

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} host_state_t;

  typedef logic [11:0] rgb444_t;

  localparam int unsigned H_TOTAL = 1040;
  localparam int unsigned V_TOTAL = 666;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pixel_mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module arb_sat_counter #(
  parameter int unsigned          WIDTH = 16,
  parameter logic [WIDTH-1:0]     MAX   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pixel_mem_arbiter.sv
// Single-port pixel memory arbiter: display reads have absolute priority, host uses free cycles.
// Optional ARB_STALL_CNT_EN adds a saturating stall_cnt output.
module pixel_mem_arbiter
  import pxl_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned MAX_WAIT = H_TOTAL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_rd,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_starve,
`ifdef ARB_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned       WAIT_W   = cnt_width(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  host_state_t       state, state_next;
  logic              grant;
  logic              op_we;
  logic              wait_inc, wait_clr;
  logic [WAIT_W-1:0] wait_cnt;

  assign grant    = (state == IDLE) && host_req && !disp_rd;
  assign wait_inc = (state == IDLE) && host_req && disp_rd;
  assign wait_clr = (state == IDLE) && (!host_req || grant);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    host_ack   = (state == ACK);
    host_rdata = ((state == ACK) && !op_we) ? mem_rdata : '0;
    disp_rdata = disp_rvalid ? mem_rdata : '0;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (disp_rd) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
    end else if (grant) begin
      mem_en    = 1'b1;
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_rvalid <= 1'b0;
      op_we       <= 1'b0;
    end else begin
      disp_rvalid <= disp_rd;
      if (grant) op_we <= host_we;
    end
  end

  // Starve flag rises on the same edge that brings wait_cnt to MAX_WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      host_starve <= 1'b0;
    end else if (wait_inc && ((32'(wait_cnt) + 32'd1) >= MAX_WAIT)) begin
      host_starve <= 1'b1;
    end
  end

  arb_sat_counter #(
    .WIDTH (WAIT_W),
    .MAX   (WAIT_MAX)
  ) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wait_inc),
    .clr   (wait_clr),
    .count (wait_cnt)
  );

`ifdef ARB_STALL_CNT_EN
  arb_sat_counter #(
    .WIDTH (16),
    .MAX   (16'hFFFF)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (wait_inc),
    .clr   (1'b0),
    .count (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// Self-checking bench for pixel_mem_arbiter with a memory model and a transaction-level reference.
module tb_pixel_mem_arbiter;

  localparam int unsigned MAXW = 1040;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_rd;
  logic [15:0] disp_addr;
  logic        disp_rvalid;
  logic [11:0] disp_rdata;
  logic        host_req;
  logic        host_we;
  logic [15:0] host_addr;
  logic [11:0] host_wdata;
  logic        host_ack;
  logic [11:0] host_rdata;
  logic        host_starve;
  logic [15:0] stall_cnt;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;

  always #5 clk = ~clk;

  pixel_mem_arbiter #(
    .ADDR_W   (16),
    .DATA_W   (12),
    .MAX_WAIT (MAXW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .disp_rd     (disp_rd),
    .disp_addr   (disp_addr),
    .disp_rvalid (disp_rvalid),
    .disp_rdata  (disp_rdata),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_ack    (host_ack),
    .host_rdata  (host_rdata),
    .host_starve (host_starve),
`ifdef ARB_STALL_CNT_EN
    .stall_cnt   (stall_cnt),
`endif
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // Frame memory the arbiter drives (1-cycle read latency).
  logic [11:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // Reference model state: expected memory contents and transaction bookkeeping.
  logic [11:0] ref_mem [0:255];
  bit          m_in_ack;
  int unsigned m_wait;
  bit          m_starve;
  int unsigned m_stall;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic d_rd, input logic [15:0] d_addr);
    logic        g;
    logic [11:0] exp_dd, exp_hr;
    disp_rd   = d_rd;
    disp_addr = d_addr;
    #1;
    g = host_req && !d_rd && !m_in_ack;
    if (!rst) begin
      chk("mem_en", mem_en, d_rd | g);
      chk("mem_we", mem_we, g & host_we);
      if (d_rd)   chk("mem_addr_disp", mem_addr, d_addr);
      else if (g) chk("mem_addr_host", mem_addr, host_addr);
      if (g && host_we) chk("mem_wdata", mem_wdata, host_wdata);
    end
    exp_dd = d_rd ? ref_mem[d_addr[7:0]] : 12'h000;
    exp_hr = (g && !host_we) ? ref_mem[host_addr[7:0]] : 12'h000;
    if (rst) begin
      m_in_ack = 1'b0;
      m_wait   = 0;
      m_starve = 1'b0;
      m_stall  = 0;
    end else begin
      if (!m_in_ack) begin
        if (!host_req || g) m_wait = 0;
        else if (m_wait < MAXW) m_wait++;
        if (host_req && d_rd && m_stall < 32'hFFFF) m_stall++;
      end
      if (m_wait == MAXW) m_starve = 1'b1;
      if (g && host_we) ref_mem[host_addr[7:0]] = host_wdata;
      m_in_ack = g;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      chk("rst_host_ack", host_ack, 1'b0);
      chk("rst_disp_rvalid", disp_rvalid, 1'b0);
      chk("rst_disp_rdata", disp_rdata, 12'h000);
      chk("rst_host_rdata", host_rdata, 12'h000);
      chk("rst_host_starve", host_starve, 1'b0);
    end else begin
      chk("disp_rvalid", disp_rvalid, d_rd);
      chk("disp_rdata", disp_rdata, exp_dd);
      chk("host_ack", host_ack, g);
      chk("host_rdata", host_rdata, exp_hr);
      chk("host_starve", host_starve, m_starve);
    end
`ifdef ARB_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
`endif
  endtask

  task automatic new_txn(input logic we);
    host_req   = 1'b1;
    host_we    = we;
    host_addr  = 16'($urandom_range(0, 255));
    host_wdata = 12'($urandom);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [11:0] v;
      v = 12'($urandom);
      mem[i]     = v;
      ref_mem[i] = v;
    end
    m_in_ack = 1'b0; m_wait = 0; m_starve = 1'b0; m_stall = 0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    disp_rd = 1'b0; disp_addr = '0;

    rst = 1'b1;
    cycle(1'b0, 16'h0);
    cycle(1'b0, 16'h0);
    rst = 1'b0;
    cycle(1'b0, 16'h0);

    // Host write with display idle.
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0040; host_wdata = 12'hF0F;
    cycle(1'b0, 16'h0);
    chk("t1_ack", host_ack, 1'b1);
    chk("t1_rdata", host_rdata, 12'h000);
    host_req = 1'b0;
    cycle(1'b0, 16'h0);

    // Host read back.
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0040;
    cycle(1'b0, 16'h0);
    chk("t2_ack", host_ack, 1'b1);
    chk("t2_rdata", host_rdata, 12'hF0F);
    host_req = 1'b0;
    cycle(1'b0, 16'h0);

    // Five display reads stall a pending host read.
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0041;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 16'(i + 16'h10));
      chk("t3_no_ack", host_ack, 1'b0);
    end
    cycle(1'b0, 16'h0);
    chk("t3_ack", host_ack, 1'b1);
`ifdef ARB_STALL_CNT_EN
    chk("t3_stall_cnt", stall_cnt, 16'd5);
`endif
    host_req = 1'b0;
    cycle(1'b0, 16'h0);

    // pxlClk-style alternating display reads with random host reads.
    new_txn(1'b0);
    for (int i = 0; i < 60; i++) begin
      cycle(i % 2 == 0, 16'($urandom_range(0, 255)));
      if (m_in_ack) new_txn(1'b0);
    end
    host_req = 1'b0;
    cycle(1'b0, 16'h0);

    // Host starvation over one full line of display reads.
    new_txn(1'b0);
    for (int i = 0; i < MAXW + 3; i++) begin
      cycle(1'b1, 16'($urandom_range(0, 255)));
      if (i == MAXW - 2) chk("t5_not_starved", host_starve, 1'b0);
    end
    chk("t5_starved", host_starve, 1'b1);
    cycle(1'b0, 16'h0);
    host_req = 1'b0;
    cycle(1'b0, 16'h0);
    cycle(1'b0, 16'h0);
    chk("t5_sticky", host_starve, 1'b1);
    rst = 1'b1;
    cycle(1'b0, 16'h0);
    rst = 1'b0;
    cycle(1'b0, 16'h0);
    chk("t5_cleared", host_starve, 1'b0);

    // Reset while in ACK aborts the access; held request is re-granted.
    new_txn(1'b0);
    cycle(1'b0, 16'h0);
    chk("t6_first_ack", host_ack, 1'b1);
    rst = 1'b1;
    cycle(1'b1, 16'h0005);
    rst = 1'b0;
    chk("t6_ack_dropped", host_ack, 1'b0);
    chk("t6_rvalid_dropped", disp_rvalid, 1'b0);
    cycle(1'b0, 16'h0);
    chk("t6_regrant", host_ack, 1'b1);
    host_req = 1'b0;
    cycle(1'b0, 16'h0);

    // Random mixed traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)));
      if (m_in_ack) begin
        if ($urandom_range(0, 1) == 0) host_req = 1'b0;
        else new_txn(1'($urandom_range(0, 1)));
      end else if (!host_req && $urandom_range(0, 9) < 4) begin
        new_txn(1'($urandom_range(0, 1)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
